// File: rtl/alu_exec_unit.sv
// RV32I integer ALU plus M-extension MUL behind a valid/ready handshake.
// Latency: one cycle for single-cycle and illegal ops, 1+WIDTH cycles for MUL (iterative shift-add).
// Backpressure: one op in flight; in_ready is low until the held result is taken with out_ready.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic             op5,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } op_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  op_t              dec_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_step;
  logic [SHW-1:0]   cnt_q;

  assign shamt = B[SHW-1:0];

  // Decode the instruction fields into a single operation code.
  always_comb begin
    dec_op = OP_ILL;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b11: dec_op = OP_ILL;
      default: begin
        if (op5 && funct7 == 7'b0000001) begin
          dec_op = (funct3 == 3'b000) ? OP_MUL : OP_ILL;
        end else begin
          case (funct3)
            3'b000:  dec_op = (op5 && funct7[5]) ? OP_SUB : OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end
      end
    endcase
  end

  // Single-cycle datapath; SUB reuses the adder with inverted B and carry-in.
  always_comb begin
    b_eff   = (dec_op == OP_SUB) ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (dec_op == OP_SUB)};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (dec_op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  alu_res = A << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  alu_res = A ^ B;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      OP_OR:   alu_res = A | B;
      OP_AND:  alu_res = A & B;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (dec_op == OP_MUL) ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, multiplier iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      Result   <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      mcand_q  <= A;
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= '0;
      if (dec_op != OP_MUL) begin
        Result   <= alu_res;
        Zero     <= (alu_res == '0);
        Negative <= alu_res[WIDTH-1];
        Carry    <= alu_c;
        Overflow <= alu_v;
        Illegal  <= (dec_op == OP_ILL);
      end
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        Result   <= acc_step;
        Zero     <= (acc_step == '0);
        Negative <= acc_step[WIDTH-1];
        Carry    <= 1'b0;
        Overflow <= 1'b0;
        Illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, multi-cycle corner sequences, random ops vs model.
// Latency is measured per op (1 or 33 cycles at WIDTH=32).
// Backpressure is exercised by holding out_ready low while a result is pending.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALUOp = '0;
  logic        op5 = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] A = '0, B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Result;
  logic        Zero, Negative, Carry, Overflow, Illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .op5(op5), .funct3(funct3), .funct7(funct7),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Negative(Negative), .Carry(Carry),
    .Overflow(Overflow), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // flags packed as {Zero, Negative, Carry, Overflow, Illegal}
  typedef struct {
    logic [1:0]  aluop;
    logic        op5;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic [4:0]  ef;
    int          el;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model from the instruction-set rules, using wide integer arithmetic.
  function automatic vec_t model(input logic [1:0] aluop, input logic o5, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    vec_t   m;
    longint sa, sb, sr;
    logic [63:0] wide;
    logic   c, v, ill;
    logic [31:0] r;
    int     kind; // 0 add, 1 sub, 2 other
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; c = 0; v = 0; ill = 0; kind = 2;
    m.el = 1;
    if (aluop == 2'b00) kind = 0;
    else if (aluop == 2'b01) kind = 1;
    else if (aluop == 2'b11) ill = 1;
    else if (o5 && f7 == 7'h01) begin
      if (f3 == 3'd0) begin
        wide = 64'(a) * 64'(b);
        r = wide[31:0];
        m.el = 33;
      end else ill = 1;
    end else begin
      case (f3)
        3'd0: kind = (o5 && f7[5]) ? 1 : 0;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    if (kind == 0) begin
      wide = 64'(a) + 64'(b);
      r = wide[31:0];
      c = wide[32];
      sr = sa + sb;
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else if (kind == 1) begin
      r = a - b;
      c = (a >= b);
      sr = sa - sb;
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    m.aluop = aluop; m.op5 = o5; m.f3 = f3; m.f7 = f7; m.a = a; m.b = b;
    m.er = r;
    m.ef = {(r == 0), r[31], c, v, ill};
    return m;
  endfunction

  // Issue one op, wait for the result, check it and consume it.
  task automatic run_op(input vec_t v, input string name);
    int lat;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    ALUOp = v.aluop; op5 = v.op5; funct3 = v.f3; funct7 = v.f7;
    A = v.a; B = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUOp = 2'($urandom); funct3 = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(v.el));
    chk({name, "_result"}, Result, v.er);
    chk({name, "_flags"}, 32'({Zero, Negative, Carry, Overflow, Illegal}), 32'(v.ef));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  vec_t tbl[13];
  vec_t rv;
  int   lat;

  initial begin
    //            aluop op5 f3   f7        a             b             result        ZNCVI     lat
    tbl[0]  = '{2'b00, 0, 3'd0, 7'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 1};
    tbl[1]  = '{2'b10, 1, 3'd0, 7'h20, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10100, 1};
    tbl[2]  = '{2'b10, 1, 3'd5, 7'h20, 32'hF0000000, 32'h00000024, 32'hFF000000, 5'b01000, 1};
    tbl[3]  = '{2'b10, 1, 3'd3, 7'h00, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'b00000, 1};
    tbl[4]  = '{2'b11, 0, 3'd0, 7'h00, 32'h12345678, 32'h00000001, 32'h00000000, 5'b10001, 1};
    tbl[5]  = '{2'b10, 1, 3'd4, 7'h01, 32'h12345678, 32'h00000003, 32'h00000000, 5'b10001, 1};
    tbl[6]  = '{2'b01, 0, 3'd0, 7'h00, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b01000, 1};
    tbl[7]  = '{2'b10, 1, 3'd2, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000, 1};
    tbl[8]  = '{2'b10, 1, 3'd5, 7'h00, 32'hF0000000, 32'h00000004, 32'h0F000000, 5'b00000, 1};
    tbl[9]  = '{2'b10, 0, 3'd0, 7'h20, 32'h00000003, 32'h00000004, 32'h00000007, 5'b00000, 1};
    tbl[10] = '{2'b00, 0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100, 1};
    tbl[11] = '{2'b10, 1, 3'd1, 7'h00, 32'h00000001, 32'h0000001F, 32'h80000000, 5'b01000, 1};
    tbl[12] = '{2'b01, 0, 3'd0, 7'h00, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110, 1};

    // Reset held two cycles with a request presented: nothing captured.
    ALUOp = 2'b00; A = 32'h7FFFFFFF; B = 32'h1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_flags", 32'({Zero, Negative, Carry, Overflow, Illegal}), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_out_ready", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // MUL with backpressure; a request offered while busy is dropped.
    ALUOp = 2'b10; op5 = 1'b1; funct3 = 3'd0; funct7 = 7'h01;
    A = 32'h0000FFFF; B = 32'h00010001; in_valid = 1'b1;
    @(posedge clk); #1;
    ALUOp = 2'b00; A = 32'd1; B = 32'd1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_latency", 32'(lat), 32'd33);
    chk("mul_result", Result, 32'hFFFFFFFF);
    chk("mul_flags", 32'({Zero, Negative, Carry, Overflow, Illegal}), 32'b01000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_result", k), Result, 32'hFFFFFFFF);
      chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("mul_consumed", 32'(out_valid), 32'd0);
    chk("mul_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("no_queued_op", 32'(out_valid), 32'd0);

    // Reset during MUL aborts it.
    ALUOp = 2'b10; op5 = 1'b1; funct3 = 3'd0; funct7 = 7'h01;
    A = 32'd7; B = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", Result, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("abort_no_result", 32'(out_valid), 32'd0);
    run_op(model(2'b00, 1'b0, 3'd0, 7'h00, 32'd2, 32'd3), "post_abort_add");

    // Random ops against the model; every eighth op forced to MUL.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] ao;
      logic [6:0] f7r;
      logic [2:0] f3r;
      logic       o5r;
      ao = 2'($urandom_range(0, 3));
      o5r = 1'($urandom);
      f3r = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7r = 7'h00;
        1: f7r = 7'h20;
        2: f7r = 7'h01;
        default: f7r = 7'($urandom);
      endcase
      if (i % 8 == 0) begin
        ao = 2'b10; o5r = 1'b1; f3r = 3'd0; f7r = 7'h01;
      end
      rv = model(ao, o5r, f3r, f7r, $urandom, $urandom);
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
